// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared FSM states and default timing for the PSRAM arbiter
package psram_arb_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_RD, WAIT_IDLE, REF} state_t;
   localparam int REFI_DEF = 780;
   localparam int POSTPONE_DEF = 8;
   localparam int TRFC_DEF = 16;
   localparam int RD_TIMEOUT_DEF = 64;
   localparam logic [3:0] OWED_MAX = 4'd8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching from one past ptr
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx
);
   always_comb begin
      int k;
      gnt = '0;
      idx = '0;
      k = 0;
      // walk from farthest to nearest so the nearest candidate overwrites last
      for (int i = NREQ; i >= 1; i--) begin
         k = int'(ptr) + i;
         k = k >= NREQ ? k - NREQ : k;
         if (req[k]) begin
            gnt = '0;
            gnt[k] = 1'b1;
            idx = k[$clog2(NREQ)-1:0];
         end
      end
   end
endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin sharing of the PSRAM user port with postponable refresh
module psram_arbiter
   import psram_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int REFI_CYCLES = REFI_DEF,
   parameter int POSTPONE_MAX = POSTPONE_DEF,
   parameter int TRFC_CYCLES = TRFC_DEF,
   parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
   input  logic                  clk100m,
   input  logic                  phy_rst,
   input  logic [NREQ-1:0]       rq_valid,
   input  logic [NREQ-1:0]       rq_we,
   input  logic [NREQ-1:0][24:0] rq_addr,
   input  logic [NREQ-1:0][31:0] rq_wdata,
   input  logic [NREQ-1:0][3:0]  rq_wbe,
   output logic [NREQ-1:0]       rq_ready,
   output logic [NREQ-1:0]       rq_rvalid,
   output logic [31:0]           rq_rdata,
   output logic                  rd_err,
   output logic [24:0]           ps_addr,
   output logic [31:0]           ps_wdata,
   output logic [3:0]            ps_wbe,
   output logic                  ps_re,
   output logic                  ps_we,
   output logic                  ps_refresh,
   input  logic                  ps_cmdready,
   input  logic [31:0]           ps_rdata,
   input  logic                  ps_rdready
);
   localparam int IW = $clog2(NREQ);
   localparam int TW = $clog2(REFI_CYCLES + 1);
   localparam int FW = $clog2(TRFC_CYCLES + 1);
   localparam int MW = $clog2(RD_TIMEOUT + 1);
   state_t state;
   logic [IW-1:0] ptr, owner, w_idx;
   logic [NREQ-1:0] w_gnt;
   logic [TW-1:0] tmr;
   logic [FW-1:0] trfc;
   logic [MW-1:0] tmo;
   logic [3:0] owed;
   logic is_rd, rd_q, expire, owe_max, ref_go, req_go, rd_edge;
   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req(rq_valid),
      .ptr(ptr),
      .gnt(w_gnt),
      .idx(w_idx)
   );
   assign expire = tmr == TW'(1);
   assign owe_max = owed >= 4'(POSTPONE_MAX);
   assign ref_go = state == IDLE && ps_cmdready && (owe_max || (rq_valid == '0 && owed != '0));
   assign req_go = state == IDLE && ps_cmdready && !owe_max && rq_valid != '0;
   assign rd_edge = ps_rdready && !rd_q;
   always_ff @(posedge clk100m) begin
      if (phy_rst) begin
         state <= IDLE;
         ptr <= IW'(NREQ - 1);
         owner <= '0;
         tmr <= TW'(REFI_CYCLES);
         owed <= '0;
         trfc <= '0;
         tmo <= '0;
         is_rd <= 1'b0;
         rd_q <= 1'b0;
         rq_ready <= '0;
         rq_rvalid <= '0;
         rq_rdata <= '0;
         rd_err <= 1'b0;
         ps_addr <= '0;
         ps_wdata <= '0;
         ps_wbe <= '0;
         ps_re <= 1'b0;
         ps_we <= 1'b0;
         ps_refresh <= 1'b0;
      end else begin
         rd_q <= ps_rdready;
         tmr <= expire ? TW'(REFI_CYCLES) : tmr - TW'(1);
         // an expiry coinciding with a refresh issue leaves owed unchanged
         owed <= expire && !ref_go && owed != OWED_MAX ? owed + 4'd1 :
                 ref_go && !expire ? owed - 4'd1 : owed;
         ps_re <= 1'b0;
         ps_we <= 1'b0;
         ps_refresh <= 1'b0;
         rq_ready <= '0;
         rq_rvalid <= '0;
         case (state)
            IDLE: begin
               if (ref_go) begin
                  state <= REF;
                  ps_refresh <= 1'b1;
                  trfc <= FW'(TRFC_CYCLES);
               end else if (req_go) begin
                  state <= ISSUE;
                  owner <= w_idx;
                  ptr <= w_idx;
                  is_rd <= !rq_we[w_idx];
                  ps_re <= !rq_we[w_idx];
                  ps_we <= rq_we[w_idx];
                  ps_addr <= rq_addr[w_idx];
                  ps_wdata <= rq_wdata[w_idx];
                  ps_wbe <= rq_wbe[w_idx];
                  rq_ready <= w_gnt;
               end
            end
            ISSUE: state <= WAIT_BUSY;
            WAIT_BUSY: begin
               if (!ps_cmdready) begin
                  state <= is_rd ? WAIT_RD : WAIT_IDLE;
                  tmo <= '0;
               end
            end
            WAIT_RD: begin
               if (rd_edge) begin
                  rq_rdata <= ps_rdata;
                  rq_rvalid <= NREQ'(1) << owner;
                  state <= WAIT_IDLE;
               end else if (tmo == MW'(RD_TIMEOUT - 1)) begin
                  rq_rdata <= '0;
                  rd_err <= 1'b1;
                  rq_rvalid <= NREQ'(1) << owner;
                  state <= WAIT_IDLE;
               end else begin
                  tmo <= tmo + MW'(1);
               end
            end
            WAIT_IDLE: state <= ps_cmdready ? IDLE : WAIT_IDLE;
            REF: begin
               if (trfc == '0) state <= IDLE;
               else trfc <= trfc - FW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
